// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, programmable latency.
// Define DMEM_RANGE_CHK_EN to flag and suppress accesses with req_addr >= DEPTH.
module dmem_responder #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wen_q, wen_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 oob_q, oob_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [15:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [15:0]          rd_count_q, rd_count_d;
  logic [15:0]          wr_count_q, wr_count_d;

  logic [15:0] mem [DEPTH];
  logic        addr_oob;
  logic        commit;
  logic        mem_we;

`ifdef DMEM_RANGE_CHK_EN
  assign addr_oob = ({16'd0, req_addr} >= 32'(DEPTH));
`else
  // Upper address bits are deliberately dropped: the index wraps modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[15:ADDR_BITS];
  assign addr_oob       = 1'b0;
`endif

  assign commit = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign mem_we = commit && wen_q && !oob_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latches are inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wen_d      = wen_q;
    idx_d      = idx_q;
    oob_d      = oob_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          idx_d   = req_addr[ADDR_BITS-1:0];
          oob_d   = addr_oob;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          err_d   = oob_q;
          if (wen_q) begin
            rdata_d = 16'h0000;
            if (!oob_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
          end else begin
            rdata_d = oob_q ? 16'h0000 : mem[idx_q];
            if (!oob_q && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 16'h0000;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      wen_q      <= 1'b0;
      idx_q      <= '0;
      oob_q      <= 1'b0;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      err_q      <= 1'b0;
      rd_count_q <= 16'h0000;
      wr_count_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      idx_q      <= idx_d;
      oob_q      <= oob_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // NOTE: the storage array is intentionally not reset; reset forces IDLE so no write can commit.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule
